// File: rtl/matvec_mul10x32.sv
// Sequential fixed-point matrix-vector multiplier y = B * x using a single shared MAC.
// Optional round-half-up before the fractional shift is enabled by defining MATVEC_ROUND_EN.
module matvec_mul10x32 #(
    parameter int ROWS  = 10,
    parameter int COLS  = 32,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ACC_W = 2*WIDTH+6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ROWS*COLS*WIDTH-1:0]    B_in,
    input  logic [COLS*WIDTH-1:0]         x_in,
    output logic                          busy,
    output logic                          done,
    output logic [ROWS*WIDTH-1:0]         y_out
);

    localparam int IW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = 2*WIDTH;
    localparam logic [IW-1:0] I_LAST = IW'(ROWS-1);
    localparam logic [CW-1:0] J_LAST = CW'(COLS-1);
    localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t                   state_r;
    logic [IW-1:0]            i_r;
    logic [CW-1:0]            j_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_fin_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [WIDTH-1:0]  b_mem [ROWS][COLS];
    logic signed [WIDTH-1:0]  x_mem [COLS];
    logic signed [WIDTH-1:0]  y_mem [ROWS];

    // Shift the (optionally rounded) accumulator down to Q format and clamp to the word range.
    function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sh;
        logic [ACC_W-WIDTH:0]    upper;
        sh    = v >>> FRAC;
        upper = sh[ACC_W-1:WIDTH-1];
        if ((&upper) || (~|upper)) begin
            return sh[WIDTH-1:0];
        end else if (sh[ACC_W-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    // Current product and the value written back at the end of a row.
    always_comb begin
        prod_s = PW'(b_mem[i_r][j_r]) * PW'(x_mem[j_r]);
`ifdef MATVEC_ROUND_EN
        acc_fin_s = acc_r + RND_HALF;
`else
        acc_fin_s = acc_r;
`endif
    end

    // Operand capture on an accepted start; later input changes do not affect the run.
    always_ff @(posedge clk) begin
        if ((state_r == IDLE) && start) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    b_mem[r][c] <= B_in[(ROWS*COLS-1-(r*COLS+c))*WIDTH +: WIDTH];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                x_mem[c] <= x_in[(COLS-1-c)*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM, accumulator, indices and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_r   <= '0;
            i_r     <= '0;
            j_r     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                y_mem[r] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        i_r     <= '0;
                        j_r     <= '0;
                        acc_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= MAC;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                    j_r   <= j_r + CW'(1);
                    if (j_r == J_LAST) begin
                        state_r <= WB;
                    end
                end
                WB: begin
                    y_mem[i_r] <= sat_word(acc_fin_s);
                    acc_r      <= '0;
                    j_r        <= '0;
                    if (i_r == I_LAST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        i_r     <= i_r + IW'(1);
                        state_r <= MAC;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_yout
        assign y_out[(ROWS-1-g)*WIDTH +: WIDTH] = y_mem[g];
    end

endmodule

// File: tb/tb_matvec_mul10x32.sv
// Self-checking bench for matvec_mul10x32: table-driven uniform fills, hand-written corner
// sequences, and randomized runs checked against a wide-integer reference model.
module tb_matvec_mul10x32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [10239:0] B_in;
    logic [1023:0]  x_in;
    logic           busy;
    logic           done;
    logic [319:0]   y_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic signed [31:0] bm [10][32];
    logic signed [31:0] xm [32];
    logic [31:0]        ye [10];

    typedef struct {
        logic [31:0] b;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;
    vec_t tbl [6];

    matvec_mul10x32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .B_in  (B_in),
        .x_in  (x_in),
        .busy  (busy),
        .done  (done),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 32; j++)
                B_in[(319-(i*32+j))*32 +: 32] = bm[i][j];
        for (int j = 0; j < 32; j++)
            x_in[(31-j)*32 +: 32] = xm[j];
    endtask

    task automatic fill(input logic [31:0] bv, input logic [31:0] xv);
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 32; j++)
                bm[i][j] = bv;
        for (int j = 0; j < 32; j++)
            xm[j] = xv;
    endtask

    // Reference: exact wide-integer dot products, optional half-LSB rounding, then clamp.
    task automatic model();
        logic signed [127:0] acc, pb, px, sh;
        for (int i = 0; i < 10; i++) begin
            acc = 128'sd0;
            for (int j = 0; j < 32; j++) begin
                pb = bm[i][j];
                px = xm[j];
                acc = acc + pb * px;
            end
`ifdef MATVEC_ROUND_EN
            acc = acc + 128'sd32768;
`endif
            sh = acc >>> 16;
            if (sh > 128'sd2147483647)        ye[i] = 32'h7FFFFFFF;
            else if (sh < -128'sd2147483648)  ye[i] = 32'h80000000;
            else                              ye[i] = sh[31:0];
        end
    endtask

    task automatic chk_y(input string tag);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_y%0d", tag, i), {32'h0, y_out[(9-i)*32 +: 32]}, {32'h0, ye[i]});
    endtask

    // One start pulse; optionally extra pulses mid-run that must be ignored.
    task automatic run_once(input string tag, input bit extra);
        int n;
        bit busy_ok;
        pack();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            start = extra && (n == 5 || n == 50);
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'd330);
        chk({tag, "_busy_run"}, {63'h0, busy_ok}, 64'h1);
        chk({tag, "_busy_at_done"}, {63'h0, busy}, 64'h0);
        chk_y(tag);
        @(negedge clk);
        chk({tag, "_done_single"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int n, ndone;
        rst = 1'b1; start = 1'b0; B_in = '0; x_in = '0;
        tbl[0] = '{32'h00010000, 32'h00010000, 32'h00200000};
        tbl[1] = '{32'h00010000, 32'hFFFF8000, 32'hFFF00000};
        tbl[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[3] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000};
        tbl[4] = '{32'h00018000, 32'h00020000, 32'h00600000};
        tbl[5] = '{32'h00000000, 32'h12345678, 32'h00000000};

        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_y", {32'h0, y_out[31:0]}, 64'h0);
        chk("rst_y_all", {63'h0, |y_out}, 64'h0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            fill(tbl[t].b, tbl[t].x);
            for (int i = 0; i < 10; i++) ye[i] = tbl[t].y;
            run_once($sformatf("tbl%0d", t), 1'b0);
        end

        // Row-scaled weights against -0.5.
        fill(32'h0, 32'hFFFF8000);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 32; j++) bm[i][j] = i << 16;
            ye[i] = -(i * 32'h00100000);
        end
        run_once("rowscale", 1'b1);

        // Single tiny product exercising truncation vs rounding, both signs.
        for (int s = 0; s < 2; s++) begin
            fill(32'h0, 32'h0);
            bm[0][0] = (s == 0) ? 32'h00000001 : 32'hFFFFFFFF;
            xm[0] = 32'h00008000;
            for (int i = 0; i < 10; i++) ye[i] = 32'h0;
`ifdef MATVEC_ROUND_EN
            ye[0] = (s == 0) ? 32'h00000001 : 32'h00000000;
`else
            ye[0] = (s == 0) ? 32'h00000000 : 32'hFFFFFFFF;
`endif
            run_once($sformatf("round%0d", s), 1'b0);
        end

        // Abort mid-run with reset.
        fill(32'h00010000, 32'h00010000);
        pack();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 50);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_y", {63'h0, |y_out}, 64'h0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 340; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        model();
        run_once("after_abort", 1'b0);

        // Randomized runs: small magnitudes then full range.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < 32; j++) begin
                    logic [31:0] v;
                    v = $urandom;
                    bm[i][j] = (r < 2) ? {{12{v[19]}}, v[19:0]} : v;
                end
            for (int j = 0; j < 32; j++) begin
                logic [31:0] v;
                v = $urandom;
                xm[j] = (r < 2) ? {{12{v[21]}}, v[21:0]} : v;
            end
            model();
            run_once($sformatf("rand%0d", r), 1'b0);
        end

        // Held start: back-to-back runs, inputs changed right after acceptance.
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 32; j++) bm[i][j] = $urandom_range(0, 32'h0003FFFF) - 32'h00020000;
        for (int j = 0; j < 32; j++) xm[j] = $urandom_range(0, 32'h0003FFFF) - 32'h00020000;
        pack();
        model();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                for (int i = 0; i < 10; i++)
                    for (int j = 0; j < 32; j++) bm[i][j] = 32'h00010000 + (i << 12);
                for (int j = 0; j < 32; j++) xm[j] = 32'hFFFF0000 + (j << 10);
                pack();
            end
        end
        chk("held_latency", 64'(n), 64'd330);
        chk_y("held_a");
        model();
        n = 0;
        @(negedge clk);
        n++;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("held_period", 64'(n), 64'd332);
        chk_y("held_b");
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
